// File: rtl/instruction_fetch.sv
// instruction_fetch: samples the PC, runs a req/ack read of instruction memory,
// and holds the returned word in ir for decode under a valid/ready handshake.
module instruction_fetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              flush,
    output logic [15:0]       fetch_count
);

    localparam logic [1:0] ADDR  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       pc_pulse;

    logic in_addr;
    logic in_req;
    logic in_hold;
    logic in_drain;
    logic issue;
    logic take;
    logic retire;
    logic accept;
    logic leave;

    assign in_addr  = (state == ADDR);
    assign in_req   = (state == REQ);
    assign in_hold  = (state == HOLD);
    assign in_drain = (state == DRAIN);

    // A flush in ADDR defers the sample so the freshly loaded PC is used.
    assign issue  = in_addr & ~flush;
    assign take   = in_req & mem_ack & ~flush;
    assign retire = (in_req | in_drain) & mem_ack;
    assign accept = in_hold & ir_ready & ~flush;
    assign leave  = in_hold & (ir_ready | flush);

    // The advance pulse must never race a PC load from the branch bus.
    assign pc_enable = pc_pulse & ~flush;

    // Next-state selection for the fetch sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            ADDR: begin
                if (!flush) state_nxt = REQ;
            end
            REQ: begin
                if (mem_ack) state_nxt = flush ? ADDR : HOLD;
                else if (flush) state_nxt = DRAIN;
            end
            HOLD: begin
                if (flush || ir_ready) state_nxt = ADDR;
            end
            DRAIN: begin
                if (mem_ack) state_nxt = ADDR;
            end
            default: state_nxt = ADDR;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) state <= ADDR;
        else     state <= state_nxt;
    end

    // Memory request: raised with a sampled address, dropped only on ack
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else if (issue) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
        end else if (retire) begin
            mem_req  <= 1'b0;
        end
    end

    // Instruction register written only by a surviving memory response
    always_ff @(posedge clk) begin
        if (rst) begin
            ir    <= '0;
            ir_pc <= '0;
        end else if (take) begin
            ir    <= mem_rdata;
            ir_pc <= mem_addr;
        end
    end

    // Valid flag toward decode, cleared on hand-off or flush
    always_ff @(posedge clk) begin
        if (rst)        ir_valid <= 1'b0;
        else if (take)  ir_valid <= 1'b1;
        else if (leave) ir_valid <= 1'b0;
    end

    // One-cycle PC advance request in the first HOLD cycle
    always_ff @(posedge clk) begin
        if (rst) pc_pulse <= 1'b0;
        else     pc_pulse <= take;
    end

    // Count of instructions handed to decode, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (rst)         fetch_count <= '0;
        else if (accept) fetch_count <= fetch_count + 16'd1;
    end

endmodule
